// File: rtl/pipeline_hazard_unit.sv
// Hazard and flush controller for the 5-stage MIPS pipeline.
// Handles taken-branch flushes, jumps, load-use stalls, and multi-cycle
// data-memory freezes. It also drains the pipeline on halt, cancels a
// halt that was fetched down a mispredicted path, and counts stall cycles.
module pipeline_hazard_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Branch,
    input  logic                  Jump,
    input  logic                  Halt,
    input  logic                  Resume,
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  ID_UsesRt,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_rd,
    input  logic                  MEM_Access,
    output logic                  PCWre,
    output logic [1:0]            PCSrc,
    output logic                  IF_ID_Wre,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic                  EX_MEM_Flush,
    output logic                  Freeze,
    output logic                  Halted,
    output logic [CNT_W-1:0]      StallCycles
);

    localparam int unsigned MCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [MCW-1:0] MEM_RELOAD   = MCW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
    localparam logic [DCW-1:0] DRAIN_RELOAD = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT_DRAIN = 2'd1,
        HALTED     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic             mem_busy_q, mem_busy_d;
    logic [MCW-1:0]   mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic luse;
    logic mem_freeze;

    assign luse = EX_MemRead && (EX_rd != '0) &&
                  ((EX_rd == ID_rs) || (ID_UsesRt && (EX_rd == ID_rt)));

    // Memory freeze request: a new access starts one unless a branch is
    // flushing the same cycle; the release cycle (count 0) never freezes.
    always_comb begin
        mem_freeze = 1'b0;
        if ((MEM_LATENCY > 0) && (state_q != HALTED)) begin
            if (mem_busy_q) begin
                mem_freeze = (mem_cnt_q != '0);
            end else begin
                mem_freeze = MEM_Access && !Branch;
            end
        end
    end

    // State register and counters, cleared asynchronously.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            mem_busy_q  <= 1'b0;
            mem_cnt_q   <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            mem_busy_q  <= mem_busy_d;
            mem_cnt_q   <= mem_cnt_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state logic for the FSM, memory-freeze tracker and stall counter.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        mem_busy_d  = mem_busy_q;
        mem_cnt_d   = mem_cnt_q;
        stall_d     = stall_q;

        if ((MEM_LATENCY > 0) && (state_q != HALTED)) begin
            if (!mem_busy_q) begin
                if (MEM_Access && !Branch) begin
                    mem_busy_d = 1'b1;
                    mem_cnt_d  = MEM_RELOAD;
                end
            end else if (mem_cnt_q != '0) begin
                mem_cnt_d = mem_cnt_q - 1'b1;
            end else begin
                mem_busy_d = 1'b0;
            end
        end

        case (state_q)
            RUN: begin
                if (!Branch && !mem_freeze && !luse && !Jump && Halt) begin
                    state_d     = HALT_DRAIN;
                    drain_cnt_d = DRAIN_RELOAD;
                end
            end
            HALT_DRAIN: begin
                if (Branch) begin
                    state_d = RUN;
                end else if (!mem_freeze) begin
                    if (drain_cnt_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end
            end
            HALTED: begin
                if (Resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (!PCWre && (state_q != HALTED) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Pipeline control outputs from state and current inputs.
    always_comb begin
        PCWre        = 1'b1;
        PCSrc        = 2'b00;
        IF_ID_Wre    = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        Freeze       = 1'b0;
        Halted       = 1'b0;

        case (state_q)
            RUN: begin
                if (Branch) begin
                    PCSrc        = 2'b01;
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Flush  = 1'b1;
                    EX_MEM_Flush = 1'b1;
                end else if (mem_freeze) begin
                    PCWre     = 1'b0;
                    IF_ID_Wre = 1'b0;
                    Freeze    = 1'b1;
                end else if (luse) begin
                    PCWre       = 1'b0;
                    IF_ID_Wre   = 1'b0;
                    ID_EX_Flush = 1'b1;
                end else if (Jump) begin
                    PCSrc       = 2'b10;
                    IF_ID_Flush = 1'b1;
                end else if (Halt) begin
                    PCWre       = 1'b0;
                    IF_ID_Wre   = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            HALT_DRAIN: begin
                if (Branch) begin
                    PCSrc        = 2'b01;
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Flush  = 1'b1;
                    EX_MEM_Flush = 1'b1;
                end else if (mem_freeze) begin
                    PCWre     = 1'b0;
                    IF_ID_Wre = 1'b0;
                    Freeze    = 1'b1;
                end else begin
                    PCWre       = 1'b0;
                    IF_ID_Wre   = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            HALTED: begin
                Halted    = 1'b1;
                PCWre     = 1'b0;
                IF_ID_Wre = 1'b0;
            end
            default: begin
                PCWre = 1'b1;
            end
        endcase
    end

    assign StallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: three instances with different
// memory latency / counter width share one stimulus stream.
module tb_pipeline_hazard_unit;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Branch, Jump, Halt, Resume, ID_UsesRt, EX_MemRead, MEM_Access;
    logic [4:0] ID_rs, ID_rt, EX_rd;

    logic        a_PCWre, a_IF_ID_Wre, a_IF_ID_Flush, a_ID_EX_Flush, a_EX_MEM_Flush, a_Freeze, a_Halted;
    logic [1:0]  a_PCSrc;
    logic [15:0] a_Stall;
    logic        b_PCWre, b_IF_ID_Wre, b_IF_ID_Flush, b_ID_EX_Flush, b_EX_MEM_Flush, b_Freeze, b_Halted;
    logic [1:0]  b_PCSrc;
    logic [1:0]  b_Stall;
    logic        c_PCWre, c_IF_ID_Wre, c_IF_ID_Flush, c_ID_EX_Flush, c_EX_MEM_Flush, c_Freeze, c_Halted;
    logic [1:0]  c_PCSrc;
    logic [15:0] c_Stall;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_unit #(.REG_ADDR_W(5), .MEM_LATENCY(2), .DRAIN_CYCLES(3), .CNT_W(16)) dut_a (
        .CLK(CLK), .Reset(Reset), .Branch(Branch), .Jump(Jump), .Halt(Halt), .Resume(Resume),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
        .EX_rd(EX_rd), .MEM_Access(MEM_Access), .PCWre(a_PCWre), .PCSrc(a_PCSrc),
        .IF_ID_Wre(a_IF_ID_Wre), .IF_ID_Flush(a_IF_ID_Flush), .ID_EX_Flush(a_ID_EX_Flush),
        .EX_MEM_Flush(a_EX_MEM_Flush), .Freeze(a_Freeze), .Halted(a_Halted), .StallCycles(a_Stall)
    );

    pipeline_hazard_unit #(.REG_ADDR_W(5), .MEM_LATENCY(3), .DRAIN_CYCLES(3), .CNT_W(2)) dut_b (
        .CLK(CLK), .Reset(Reset), .Branch(Branch), .Jump(Jump), .Halt(Halt), .Resume(Resume),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
        .EX_rd(EX_rd), .MEM_Access(MEM_Access), .PCWre(b_PCWre), .PCSrc(b_PCSrc),
        .IF_ID_Wre(b_IF_ID_Wre), .IF_ID_Flush(b_IF_ID_Flush), .ID_EX_Flush(b_ID_EX_Flush),
        .EX_MEM_Flush(b_EX_MEM_Flush), .Freeze(b_Freeze), .Halted(b_Halted), .StallCycles(b_Stall)
    );

    pipeline_hazard_unit #(.REG_ADDR_W(5), .MEM_LATENCY(0), .DRAIN_CYCLES(3), .CNT_W(16)) dut_c (
        .CLK(CLK), .Reset(Reset), .Branch(Branch), .Jump(Jump), .Halt(Halt), .Resume(Resume),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
        .EX_rd(EX_rd), .MEM_Access(MEM_Access), .PCWre(c_PCWre), .PCSrc(c_PCSrc),
        .IF_ID_Wre(c_IF_ID_Wre), .IF_ID_Flush(c_IF_ID_Flush), .ID_EX_Flush(c_ID_EX_Flush),
        .EX_MEM_Flush(c_EX_MEM_Flush), .Freeze(c_Freeze), .Halted(c_Halted), .StallCycles(c_Stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Branch = 0; Jump = 0; Halt = 0; Resume = 0;
        ID_UsesRt = 0; EX_MemRead = 0; MEM_Access = 0;
        ID_rs = '0; ID_rt = '0; EX_rd = '0;

        // reset state
        settle();
        chk("rst_pcwre", a_PCWre, 1);
        chk("rst_ifidwre", a_IF_ID_Wre, 1);
        chk("rst_pcsrc", a_PCSrc, 0);
        chk("rst_flush", {a_IF_ID_Flush, a_ID_EX_Flush, a_EX_MEM_Flush}, 0);
        chk("rst_freeze", a_Freeze, 0);
        chk("rst_halted", a_Halted, 0);
        chk("rst_stall", a_Stall, 0);
        tick();
        Reset = 1'b0;

        // load-use on rs
        EX_MemRead = 1; EX_rd = 5'd8; ID_rs = 5'd8;
        settle();
        chk("luse_pcwre", a_PCWre, 0);
        chk("luse_ifidwre", a_IF_ID_Wre, 0);
        chk("luse_idex", a_ID_EX_Flush, 1);
        tick();
        // destination r0 never stalls
        EX_rd = 5'd0; ID_rs = 5'd0;
        settle();
        chk("r0_pcwre", a_PCWre, 1);
        chk("r0_idex", a_ID_EX_Flush, 0);
        chk("luse_stall1", a_Stall, 1);
        tick();
        // rt match ignored unless ID_UsesRt
        EX_rd = 5'd9; ID_rt = 5'd9;
        settle();
        chk("rt_unused_pcwre", a_PCWre, 1);
        tick();
        ID_UsesRt = 1;
        settle();
        chk("rt_used_pcwre", a_PCWre, 0);
        tick();
        EX_MemRead = 0; ID_UsesRt = 0; EX_rd = '0; ID_rt = '0;
        settle();
        chk("luse_stall2", a_Stall, 2);

        // MEM_LATENCY=2, access held 3 cycles
        MEM_Access = 1;
        settle();
        chk("mem_frz1", a_Freeze, 1);
        chk("mem_frz1_pcwre", a_PCWre, 0);
        chk("lat0_frz1", c_Freeze, 0);
        chk("lat0_pcwre", c_PCWre, 1);
        tick();
        settle();
        chk("mem_frz2", a_Freeze, 1);
        chk("lat0_frz2", c_Freeze, 0);
        tick();
        settle();
        chk("mem_release", a_Freeze, 0);
        chk("mem_release_pcwre", a_PCWre, 1);
        chk("mem_stall", a_Stall, 4);
        chk("lat0_frz3", c_Freeze, 0);
        tick();
        MEM_Access = 0;
        tick();

        // reset in cycle 2 of a 3-cycle freeze
        MEM_Access = 1;
        settle();
        chk("l3_frz1", b_Freeze, 1);
        tick();
        MEM_Access = 0;
        settle();
        chk("l3_frz2", b_Freeze, 1);
        Reset = 1'b1;
        #1;
        chk("rstmid_freeze", b_Freeze, 0);
        chk("rstmid_pcwre", b_PCWre, 1);
        chk("rstmid_stall", b_Stall, 0);
        tick();
        Reset = 1'b0;
        MEM_Access = 1;
        settle();
        chk("l3_again1", b_Freeze, 1);
        tick();
        MEM_Access = 0;
        settle();
        chk("l3_again2", b_Freeze, 1);
        tick();
        settle();
        chk("l3_again3", b_Freeze, 1);
        tick();
        settle();
        chk("l3_release", b_Freeze, 0);
        chk("l3_stall", b_Stall, 3);
        chk("a_stall_post_rst", a_Stall, 2);

        // halt drain, 3 cycles
        Halt = 1;
        settle();
        chk("halt_pcwre", a_PCWre, 0);
        chk("halt_idex", a_ID_EX_Flush, 1);
        tick();
        Halt = 0;
        settle();
        chk("drain1_pcwre", a_PCWre, 0);
        chk("drain1_ifidwre", a_IF_ID_Wre, 0);
        chk("drain1_idex", a_ID_EX_Flush, 1);
        chk("drain1_halted", a_Halted, 0);
        chk("sat_stall", b_Stall, 3);
        tick();
        tick();
        settle();
        chk("drain3_halted", a_Halted, 0);
        tick();
        settle();
        chk("halted", a_Halted, 1);
        chk("halted_pcwre", a_PCWre, 0);
        chk("halted_stall", a_Stall, 6);
        tick();
        Resume = 1;
        settle();
        chk("resume_cyc_halted", a_Halted, 1);
        chk("halted_nocount", a_Stall, 6);
        tick();
        Resume = 0;
        settle();
        chk("resumed_halted", a_Halted, 0);
        chk("resumed_pcwre", a_PCWre, 1);
        tick();

        // speculative halt cancelled by branch on drain cycle 2
        Halt = 1;
        settle();
        tick();
        Halt = 0;
        settle();
        tick();
        Branch = 1;
        settle();
        chk("cancel_pcsrc", a_PCSrc, 1);
        chk("cancel_pcwre", a_PCWre, 1);
        chk("cancel_flush", {a_IF_ID_Flush, a_ID_EX_Flush, a_EX_MEM_Flush}, 3'b111);
        tick();
        Branch = 0;
        settle();
        chk("cancel_run_pcwre", a_PCWre, 1);
        chk("cancel_run_idex", a_ID_EX_Flush, 0);
        chk("cancel_stall", a_Stall, 8);
        tick();
        tick();
        settle();
        chk("cancel_never_halt", a_Halted, 0);

        // branch beats jump and load-use
        Branch = 1; Jump = 1; EX_MemRead = 1; EX_rd = 5'd8; ID_rs = 5'd8;
        settle();
        chk("prio_pcsrc", a_PCSrc, 1);
        chk("prio_flush", {a_IF_ID_Flush, a_ID_EX_Flush, a_EX_MEM_Flush}, 3'b111);
        chk("prio_pcwre", a_PCWre, 1);
        tick();
        Branch = 0;
        settle();
        chk("jluse_pcwre", a_PCWre, 0);
        chk("jluse_pcsrc", a_PCSrc, 0);
        chk("jluse_ifflush", a_IF_ID_Flush, 0);
        chk("jluse_idex", a_ID_EX_Flush, 1);
        tick();
        EX_MemRead = 0; EX_rd = '0; ID_rs = '0;
        settle();
        chk("jump_pcsrc", a_PCSrc, 2);
        chk("jump_ifflush", a_IF_ID_Flush, 1);
        chk("jump_idex", a_ID_EX_Flush, 0);
        chk("jump_pcwre", a_PCWre, 1);
        tick();
        Jump = 0;
        settle();
        chk("final_stall", a_Stall, 9);
        chk("final_sat", b_Stall, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Sequential hazard and flush controller for the 5-stage MIPS pipeline. It is the successor to the purely combinational Branch/ControlSrc flush logic in the control unit, generalised with the following:
- parametrised multi-cycle data-memory stall
- parametrised halt drain
- speculative-halt cancel on taken branch
- load-use detection moved in-block
- stall performance counter

It sits beside the pipeline registers and drives PC, IF/ID, ID/EX and EX/MEM write-enable and flush controls.

Parameters:
REG_ADDR_W, 5, register-specifier width
MEM_LATENCY, 1, cycles the pipeline freezes per data-memory access (0 = no freeze)
DRAIN_CYCLES, 3, cycles to drain EX/MEM/WB after halt decoded in ID (≥1)
CNT_W, 16, StallCycles width

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high
Branch  in  1  taken branch resolved in MEM
Jump  in  1  j/jal/jr decoded in ID
Halt  in  1  halt decoded in ID
Resume  in  1  restart request while halted
ID_rs  in  REG_ADDR_W  rs of instruction in ID
ID_rt  in  REG_ADDR_W  rt of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt
EX_MemRead  in  1  instruction in EX is lw
EX_rd  in  REG_ADDR_W  destination of instruction in EX
MEM_Access  in  1  lw/sw present in MEM
PCWre  out  1  PC write enable
PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
IF_ID_Wre  out  1  IF/ID write enable
IF_ID_Flush  out  1  IF/ID bubble
ID_EX_Flush  out  1  ID/EX bubble
EX_MEM_Flush  out  1  EX/MEM bubble
Freeze  out  1  hold every pipeline register and PC
Halted  out  1  core halted
StallCycles  out  CNT_W  cycles with PCWre=0 outside HALTED, saturating

Behaviour:
- State: FSM {RUN, HALT_DRAIN, HALTED}, drain_cnt, mem_busy, mem_cnt, StallCycles. Outputs are combinational from state plus inputs.
- Reset (any time, mid-freeze or mid-drain): RUN, mem_busy=0, counters 0. With inputs idle, outputs are PCWre=1, IF_ID_Wre=1, PCSrc=00, all flushes 0, Freeze=0, Halted=0, StallCycles=0.
- Load-use hazard: luse = EX_MemRead & EX_rd≠0 & (EX_rd==ID_rs | (ID_UsesRt & EX_rd==ID_rt)).
- Memory freeze (RUN and HALT_DRAIN only; MEM_LATENCY>0):
  - Access seen with mem_busy=0: Freeze=1; next mem_busy=1, mem_cnt=MEM_LATENCY-1.
  - mem_busy=1 and mem_cnt≠0: Freeze=1, mem_cnt decrements.
  - mem_busy=1 and mem_cnt=0: release cycle, Freeze=0, mem_busy clears. MEM_Access in the release cycle is ignored.
  - Result: exactly MEM_LATENCY frozen cycles per access. Freeze forces PCWre=0, IF_ID_Wre=0, flushes 0.
- RUN priority, highest first:
  1. Branch: PCSrc=01, PCWre=1, all three flushes=1 for one cycle.
  2. Freeze.
  3. luse: PCWre=0, IF_ID_Wre=0, ID_EX_Flush=1. A Jump waiting on a load retries next cycle.
  4. Jump: PCSrc=10, IF_ID_Flush=1.
  5. Halt: PCWre=0, IF_ID_Wre=0, ID_EX_Flush=1; next state HALT_DRAIN, drain_cnt=DRAIN_CYCLES-1.
- Branch and MEM_Access asserted together is illegal; Branch wins and no freeze starts.
- HALT_DRAIN:
  - PCWre=0, IF_ID_Wre=0, ID_EX_Flush=1.
  - drain_cnt decrements only when Freeze=0.
  - When drain_cnt=0 and Freeze=0, next state is HALTED.
  - Branch: the halt was speculative. Branch flush outputs apply (PCWre=1, PCSrc=01); next state RUN.
- HALTED: Halted=1, PCWre=0, IF_ID_Wre=0, flushes 0, inputs other than Resume/Reset ignored. Resume → RUN next cycle; fetch continues at the instruction after halt.
- StallCycles: increments every cycle with PCWre=0 and state≠HALTED, including the cycle that enters HALT_DRAIN. Holds at 2^CNT_W-1.

Test Plan:
1. Reset asserted mid-freeze (MEM_LATENCY=3, cycle 2 of freeze) → same cycle: Freeze=0, PCWre=1, StallCycles=0; next access freezes a full 3 cycles.
2. EX_MemRead=1, EX_rd=8, ID_rs=8 → one cycle PCWre=0, IF_ID_Wre=0, ID_EX_Flush=1. Same with EX_rd=0 → no stall.
3. MEM_LATENCY=2, MEM_Access held high 3 cycles → Freeze=1,1,0; StallCycles+=2. MEM_LATENCY=0 → Freeze never asserts.
4. Halt in ID, DRAIN_CYCLES=3, no memory traffic → HALT_DRAIN for 3 cycles, Halted=1 on cycle 4. Resume → Halted=0, PCWre=1 next cycle.
5. Halt followed by Branch on drain cycle 2 → PCSrc=01, all flushes 1, state RUN, Halted never asserts.
6. Branch, Jump and luse all asserted together → PCSrc=01, all flushes 1. Then Jump with luse → stall first, PCSrc=10 + IF_ID_Flush the following cycle. CNT_W=2 with 5 stall cycles → StallCycles=3.
